// File: rtl/ysyx_22040237_lsu_ctrl_pkg.sv
// Shared definitions for the LSU controller: LS-bus bit indices, FSM states,
// access-size masks and the access-legality checks.
package ysyx_22040237_lsu_ctrl_pkg;

  localparam int unsigned LsLoad  = 0;
  localparam int unsigned LsStore = 1;
  localparam int unsigned LsUsign = 2;
  localparam int unsigned LsByte  = 3;
  localparam int unsigned LsHalf  = 4;
  localparam int unsigned LsWord  = 5;
  localparam int unsigned LsDw    = 6;

  localparam logic [7:0] MaskByte = 8'h01;
  localparam logic [7:0] MaskHalf = 8'h03;
  localparam logic [7:0] MaskWord = 8'h0F;
  localparam logic [7:0] MaskDw   = 8'hFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StResp = 2'd3
  } lsu_state_e;

  // Size vectors are one-hot {dw, word, half, byte}.
  function automatic logic [7:0] size_mask(input logic [3:0] size);
    case (size)
      4'b0001: size_mask = MaskByte;
      4'b0010: size_mask = MaskHalf;
      4'b0100: size_mask = MaskWord;
      4'b1000: size_mask = MaskDw;
      default: size_mask = 8'h00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [3:0] size, input logic [2:0] off);
    is_misaligned = (size[1] & off[0]) | (size[2] & (off[1:0] != 2'b00)) |
                    (size[3] & (off != 3'b000));
  endfunction

  function automatic logic is_malformed(input logic load, input logic store,
                                        input logic [3:0] size);
    logic one_hot;
    one_hot = (size == 4'b0001) | (size == 4'b0010) | (size == 4'b0100) | (size == 4'b1000);
    is_malformed = (load == store) | ~one_hot;
  endfunction

endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// Byte-lane alignment: store strobe and data shift, load extraction and
// sign/zero extension. Purely combinational.
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_ctrl_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [3:0]  size,
  input  logic        usign,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [7:0]  wstrb,
  output logic [63:0] wdata_sh,
  output logic [63:0] rdata_ext
);

  logic [63:0] rdata_sh;

  assign wstrb    = size_mask(size) << off;
  assign wdata_sh = wdata << {off, 3'b000};
  assign rdata_sh = rdata >> {off, 3'b000};

  always_comb begin
    rdata_ext = 64'h0;
    case (size)
      4'b0001: rdata_ext = usign ? {56'h0, rdata_sh[7:0]}
                                 : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
      4'b0010: rdata_ext = usign ? {48'h0, rdata_sh[15:0]}
                                 : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
      4'b0100: rdata_ext = usign ? {32'h0, rdata_sh[31:0]}
                                 : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
      4'b1000: rdata_ext = rdata_sh;
      default: rdata_ext = 64'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_22040237_lsu_ctrl.sv
// Load/store unit controller: accepts one op at a time from EXU, runs the
// req/gnt/rvalid handshake and produces a one-cycle load writeback.
module ysyx_22040237_lsu_ctrl
  import ysyx_22040237_lsu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid_i,
  input  logic [6:0]  ls_info_bus_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  input  logic [4:0]  rd_idx_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_wstrb_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [63:0] wb_data_o,
  output logic        misalign_o
);

  lsu_state_e  state_q, state_d;
  logic [63:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  size_q;
  logic        usign_q, store_q;
  logic [4:0]  rd_idx_q;

  logic [3:0]  size_in;
  logic        bad_op, can_accept, accept;
  logic [7:0]  wstrb;
  logic [63:0] wdata_sh, rdata_ext;

  assign size_in = {ls_info_bus_i[LsDw], ls_info_bus_i[LsWord],
                    ls_info_bus_i[LsHalf], ls_info_bus_i[LsByte]};
  assign bad_op  = is_malformed(ls_info_bus_i[LsLoad], ls_info_bus_i[LsStore], size_in) |
                   is_misaligned(size_in, addr_i[2:0]);
  assign can_accept = ~rst & ls_valid_i & ((state_q == StIdle) | (state_q == StResp));
  assign accept     = can_accept & ~bad_op;

  ysyx_22040237_lsu_align u_align (
    .off      (addr_q[2:0]),
    .size     (size_q),
    .usign    (usign_q),
    .wdata    (wdata_q),
    .rdata    (mem_rdata_i),
    .wstrb    (wstrb),
    .wdata_sh (wdata_sh),
    .rdata_ext(rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= 64'h0;
      wdata_q  <= 64'h0;
      rdata_q  <= 64'h0;
      size_q   <= 4'h0;
      usign_q  <= 1'b0;
      store_q  <= 1'b0;
      rd_idx_q <= 5'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q   <= addr_i;
        wdata_q  <= wdata_i;
        size_q   <= size_in;
        usign_q  <= ls_info_bus_i[LsUsign];
        store_q  <= ls_info_bus_i[LsStore];
        rd_idx_q <= rd_idx_i;
      end
      if ((state_q == StWait) && mem_rvalid_i && !store_q) begin
        rdata_q <= rdata_ext;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StReq;
      StReq:   if (mem_gnt_i) state_d = StWait;
      StWait:  if (mem_rvalid_i) state_d = StResp;
      StResp:  state_d = accept ? StReq : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stall_o     = accept | (state_q == StReq) | (state_q == StWait);
    mem_req_o   = (state_q == StReq);
    mem_we_o    = (state_q == StReq) & store_q;
    mem_addr_o  = {addr_q[63:3], 3'b000};
    mem_wdata_o = wdata_sh;
    mem_wstrb_o = store_q ? wstrb : 8'h00;
    wb_valid_o  = (state_q == StResp) & ~store_q;
    wb_rd_idx_o = rd_idx_q;
    wb_data_o   = rdata_q;
    misalign_o  = can_accept & bad_op;
  end

endmodule

// File: tb/tb_ysyx_22040237_lsu_ctrl.sv
// Directed bench for the LSU controller with hand-computed expectations.
module tb_ysyx_22040237_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid_i;
  logic [6:0]  ls_info_bus_i;
  logic [63:0] addr_i, wdata_i;
  logic [4:0]  rd_idx_i;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wstrb_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_idx_o;
  logic [63:0] wb_data_o;
  logic        misalign_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // {dw, word, half, byte, usign, store, load}
  localparam logic [6:0] OpLb  = 7'b0001001;
  localparam logic [6:0] OpLbu = 7'b0001101;
  localparam logic [6:0] OpSh  = 7'b0010010;
  localparam logic [6:0] OpLw  = 7'b0100001;
  localparam logic [6:0] OpLd  = 7'b1000001;
  localparam logic [6:0] OpBad = 7'b0001011;

  always #5 clk = ~clk;

  ysyx_22040237_lsu_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .ls_valid_i   (ls_valid_i),
    .ls_info_bus_i(ls_info_bus_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .rd_idx_i     (rd_idx_i),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_idx_o  (wb_rd_idx_o),
    .wb_data_o    (wb_data_o),
    .misalign_o   (misalign_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [6:0] info, input logic [63:0] a,
                        input logic [63:0] wd, input logic [4:0] rd);
    ls_valid_i    = v;
    ls_info_bus_i = info;
    addr_i        = a;
    wdata_i       = wd;
    rd_idx_i      = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    rst = 1'b1;
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = 64'h0;
    tick();
    tick();
    #1;
    check("rst_stall", 64'(stall_o), 64'h0);
    check("rst_req", 64'(mem_req_o), 64'h0);
    check("rst_we", 64'(mem_we_o), 64'h0);
    check("rst_wstrb", 64'(mem_wstrb_o), 64'h0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'h0);
    check("rst_misalign", 64'(misalign_o), 64'h0);
    check("rst_addr", mem_addr_o, 64'h0);
    check("rst_wdata", mem_wdata_o, 64'h0);
    check("rst_wb_data", wb_data_o, 64'h0);
    check("rst_wb_rd", 64'(wb_rd_idx_o), 64'h0);

    // Idle with garbage on the bus and ls_valid low.
    tick();
    rst = 1'b0;
    set_op(1'b0, OpLw, 64'h8000_0002, 64'hFFFF, 5'd3);
    #1;
    check("idle_junk_stall", 64'(stall_o), 64'h0);
    check("idle_junk_misalign", 64'(misalign_o), 64'h0);

    // lb at 0x8000_0003, sign-extended 0x80.
    tick();
    set_op(1'b1, OpLb, 64'h8000_0003, 64'h0, 5'd5);
    #1;
    check("lb_accept_stall", 64'(stall_o), 64'h1);
    check("lb_accept_misalign", 64'(misalign_o), 64'h0);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b1;
    #1;
    check("lb_req", 64'(mem_req_o), 64'h1);
    check("lb_we", 64'(mem_we_o), 64'h0);
    check("lb_addr", mem_addr_o, 64'h8000_0000);
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'h0000_0000_8000_0000;
    #1;
    check("lb_wait_req", 64'(mem_req_o), 64'h0);
    check("lb_wait_stall", 64'(stall_o), 64'h1);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("lb_wb_valid", 64'(wb_valid_o), 64'h1);
    check("lb_wb_data", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_wb_rd", 64'(wb_rd_idx_o), 64'd5);
    check("lb_resp_stall", 64'(stall_o), 64'h0);
    tick();
    #1;
    check("lb_wb_pulse", 64'(wb_valid_o), 64'h0);

    // sh 0x1234 at offset 6.
    tick();
    set_op(1'b1, OpSh, 64'h8000_0006, 64'h1234, 5'd9);
    #1;
    check("sh_accept_stall", 64'(stall_o), 64'h1);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b1;
    #1;
    check("sh_req", 64'(mem_req_o), 64'h1);
    check("sh_we", 64'(mem_we_o), 64'h1);
    check("sh_wstrb", 64'(mem_wstrb_o), 64'hC0);
    check("sh_wdata", mem_wdata_o, 64'h1234_0000_0000_0000);
    check("sh_addr", mem_addr_o, 64'h8000_0000);
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    #1;
    check("sh_wait_wb", 64'(wb_valid_o), 64'h0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("sh_resp_wb", 64'(wb_valid_o), 64'h0);
    check("sh_resp_stall", 64'(stall_o), 64'h0);

    // Misaligned lw and malformed op.
    tick();
    set_op(1'b1, OpLw, 64'h8000_0002, 64'h0, 5'd1);
    #1;
    check("lw_mis_pulse", 64'(misalign_o), 64'h1);
    check("lw_mis_stall", 64'(stall_o), 64'h0);
    check("lw_mis_req", 64'(mem_req_o), 64'h0);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    #1;
    check("lw_mis_once", 64'(misalign_o), 64'h0);
    check("lw_mis_req_after", 64'(mem_req_o), 64'h0);
    check("lw_mis_stall_after", 64'(stall_o), 64'h0);
    tick();
    set_op(1'b1, OpBad, 64'h8000_0000, 64'h0, 5'd1);
    #1;
    check("bad_pulse", 64'(misalign_o), 64'h1);
    check("bad_stall", 64'(stall_o), 64'h0);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    #1;
    check("bad_req_after", 64'(mem_req_o), 64'h0);

    // ld with a four-cycle REQ phase and three-cycle WAIT phase.
    stall_cnt = 0;
    mem_rdata_i = 64'hDEAD_BEEF_CAFE_F00D;
    for (int c = 0; c <= 8; c++) begin
      tick();
      set_op(c == 0, OpLd, 64'h8000_0020, 64'h0, 5'd12);
      mem_gnt_i    = (c == 4);
      mem_rvalid_i = (c == 7);
      #1;
      if (stall_o) stall_cnt++;
      if (c >= 1 && c <= 4) begin
        check($sformatf("slow_req_c%0d", c), 64'(mem_req_o), 64'h1);
        check($sformatf("slow_addr_c%0d", c), mem_addr_o, 64'h8000_0020);
      end
    end
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    check("slow_stall_cycles", 64'(stall_cnt), 64'd8);
    check("slow_resp_stall", 64'(stall_o), 64'h0);
    check("slow_wb_data", wb_data_o, 64'hDEAD_BEEF_CAFE_F00D);

    // Back-to-back ld then lbu, second op accepted in RESP.
    tick();
    set_op(1'b1, OpLd, 64'h8000_0010, 64'h0, 5'd4);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    tick();
    mem_rvalid_i = 1'b0;
    set_op(1'b1, OpLbu, 64'h8000_0015, 64'h0, 5'd7);
    #1;
    check("b2b_ld_wb_valid", 64'(wb_valid_o), 64'h1);
    check("b2b_ld_wb_data", wb_data_o, 64'h0123_4567_89AB_CDEF);
    check("b2b_ld_wb_rd", 64'(wb_rd_idx_o), 64'd4);
    check("b2b_resp_stall", 64'(stall_o), 64'h1);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b1;
    #1;
    check("b2b_no_idle_req", 64'(mem_req_o), 64'h1);
    check("b2b_lbu_addr", mem_addr_o, 64'h8000_0010);
    tick();
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'h0000_FF00_0000_0000;
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("b2b_lbu_wb_valid", 64'(wb_valid_o), 64'h1);
    check("b2b_lbu_wb_data", wb_data_o, 64'h0000_0000_0000_00FF);
    check("b2b_lbu_wb_rd", 64'(wb_rd_idx_o), 64'd7);

    // Reset while waiting for the response; the late rvalid is ignored.
    tick();
    set_op(1'b1, OpLd, 64'h8000_0040, 64'h0, 5'd2);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'h1111_2222_3333_4444;
    #1;
    check("rstw_req", 64'(mem_req_o), 64'h0);
    check("rstw_stall", 64'(stall_o), 64'h0);
    tick();
    mem_rvalid_i = 1'b0;
    #1;
    check("rstw_wb_valid", 64'(wb_valid_o), 64'h0);
    check("rstw_stall_idle", 64'(stall_o), 64'h0);
    check("rstw_wb_data", wb_data_o, 64'h0);
    // An op accepted now must go straight to REQ, proving the FSM is in IDLE.
    set_op(1'b1, OpLd, 64'h8000_0048, 64'h0, 5'd2);
    #1;
    check("rstw_idle_accept", 64'(stall_o), 64'h1);
    tick();
    set_op(1'b0, 7'h0, 64'h0, 64'h0, 5'h0);
    #1;
    check("rstw_idle_req", 64'(mem_req_o), 64'h1);
    check("rstw_idle_addr", mem_addr_o, 64'h8000_0048);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040237_lsu_ctrl.md
YSYX_22040237_LSU_CTRL -- requirements
Module: ysyx_22040237_lsu_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL: ls_valid_i  in  1  EXU presents a load/store this cycle.
REQ-004 SHALL: ls_info_bus_i  in  7  {dw, word, half, byte, usign, store, load}, bit 0 = load.
REQ-005 SHALL: addr_i  in  64  effective address (EXU adder result).
REQ-006 SHALL: wdata_i  in  64  store data, LSB-aligned.
REQ-007 SHALL: rd_idx_i  in  5  load destination register.
REQ-008 SHALL: stall_o  out  1  holds upstream stages while high.
REQ-009 SHALL: mem_req_o / mem_we_o  out  1 / 1  memory request and write-enable.
REQ-010 SHALL: mem_addr_o  out  64  addr_i with bits [2:0] forced to 0.
REQ-011 SHALL: mem_wdata_o / mem_wstrb_o  out  64 / 8  lane-shifted store data and byte strobes.
REQ-012 SHALL: mem_gnt_i / mem_rvalid_i  in  1 / 1  request accepted / response (load data or store ack).
REQ-013 SHALL: mem_rdata_i  in  64  raw 8-byte-aligned read data.
REQ-014 SHALL: wb_valid_o / wb_rd_idx_o / wb_data_o  out  1 / 5 / 64  load writeback (one-cycle pulse).
REQ-015 SHALL: misalign_o  out  1  one-cycle pulse on a misaligned or malformed access.

Function
REQ-016 SHALL: FSM states IDLE, REQ, WAIT, RESP; accept a new op only in IDLE or RESP.
REQ-017 SHALL: on accept, register addr, size, usign, store, wdata, rd_idx; next state REQ.
REQ-018 SHALL: in REQ, hold mem_req_o=1 and all mem_* outputs stable until mem_gnt_i; on gnt go to WAIT.
REQ-019 SHALL: ignore mem_rvalid_i outside WAIT; memory guarantees rvalid no earlier than the cycle after gnt.
REQ-020 SHALL: in WAIT, mem_rvalid_i moves to RESP; a load captures the extracted data.
REQ-021 SHALL: in RESP, assert wb_valid_o=1 for a load only; a store gives wb_valid_o=0; next state is REQ on a new accept, otherwise IDLE.
REQ-022 SHALL: stall_o = (accept condition in IDLE/RESP) | state==REQ | state==WAIT; stall_o=0 in RESP unless a new op is accepted.
REQ-023 SHALL: minimum op latency is accept cycle to RESP in 3 cycles (gnt in first REQ cycle, rvalid in first WAIT cycle).
REQ-024 SHALL: misaligned means half with addr[0]!=0, word with addr[1:0]!=0, or dw with addr[2:0]!=0.
REQ-025 SHALL: a malformed op has load==store or not exactly one size bit set.
REQ-026 SHALL: a misaligned or malformed op pulses misalign_o, issues no request, raises no stall, and stays in or returns to IDLE.
REQ-027 SHALL: store strobe = size mask (0x01/0x03/0x0F/0xFF) << addr[2:0].
REQ-028 SHALL: store wdata = wdata_i << (8*addr[2:0]).
REQ-029 SHALL: load data = mem_rdata_i >> (8*addr[2:0]), truncated to size, then zero-extended if usign else sign-extended; dw ignores usign.
REQ-030 SHALL: with ls_valid_i=0, outputs and state are unaffected by ls_info_bus_i, addr_i and wdata_i.

Reset
REQ-031 SHALL: rst drives state to IDLE and outputs stall_o, mem_req_o, mem_we_o, mem_wstrb_o, wb_valid_o, misalign_o to 0.
REQ-032 SHALL: rst also drives mem_addr_o, mem_wdata_o, wb_data_o to 0 and wb_rd_idx_o to 0.
REQ-033 SHALL: rst mid-transaction abandons the op, drops mem_req_o next cycle, and ignores any later rvalid.

Structure
REQ-034 SHALL: the shared defines file holds LS-bus bit indices, FSM state encodings and size-mask constants.
REQ-035 SHALL: combinational strobe, lane-shift and extension logic lives in sub-module ysyx_22040237_lsu_align; the FSM and registers live in lsu_ctrl.

Verification
REQ-036 SHALL: lb at addr 0x8000_0003 with rdata 0x0000_0000_8000_0000 -> mem_addr_o 0x8000_0000, wb_data_o 0xFFFF_FFFF_FFFF_FF80.
REQ-037 SHALL: sh of 0x1234 at 0x...06 -> mem_wstrb_o 0xC0, mem_wdata_o 0x1234_0000_0000_0000, wb_valid_o stays 0.
REQ-038 SHALL: lw at 0x...02 -> misalign_o pulses once, mem_req_o stays 0, stall_o stays 0.
REQ-039 SHALL: gnt delayed 4 cycles and rvalid delayed 3 cycles -> stall_o high for 8 consecutive cycles and request outputs stable throughout.
REQ-040 SHALL: back-to-back ld then lbu with a new op in RESP -> REQ is re-entered with no IDLE cycle, and both writebacks are correct (lbu of 0xFF gives 0xFF).
REQ-041 SHALL: rst asserted in WAIT, then rvalid -> wb_valid_o stays 0 and state is IDLE.
